// File: rtl/uart_rx_fifo.sv
// UART receiver sampling RX once per bit on the bit clock, with parity/framing
// checks and a small FIFO of received words read through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CTS_MARGIN  = 1
) (
  input  logic                          clock_115200hz,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rts,
  output logic                          cts,
  output logic                          receiving,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_error,
  output logic                          rx_framing_error,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clear_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 perr;
  logic                 ferr;

  // Completed frame staged for one cycle before it enters the FIFO.
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data;
  logic                 push_perr;
  logic                 push_ferr;

  always_ff @(posedge clock_115200hz or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      receiving <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      push_perr <= 1'b0;
      push_ferr <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx) begin
            state     <= S_DATA;
            receiving <= 1'b1;
            bit_cnt   <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
          end
        end
        S_DATA: begin
          shreg <= {rx, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            stop_cnt <= 1'b0;
            state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_PARITY: begin
          perr  <= (PARITY_MODE == 2) ? ~(^{shreg, rx}) : (^{shreg, rx});
          state <= S_STOP;
        end
        S_STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            push_q    <= 1'b1;
            push_data <= shreg;
            push_perr <= perr;
            push_ferr <= ferr | ~rx;
            receiving <= 1'b0;
            state     <= rx ? S_IDLE : S_BREAK;
          end else begin
            ferr     <= ferr | ~rx;
            stop_cnt <= 1'b1;
          end
        end
        S_BREAK: begin
          if (rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign wr_en    = push_q && (!full || pop);

  assign {rx_framing_error, rx_parity_error, rx_data} = rx_valid ? mem[rd_ptr] : '0;
  assign cts = rts && ((FIFO_DEPTH - int'(fifo_count)) > CTS_MARGIN);

  always_ff @(posedge clock_115200hz) begin
    if (wr_en) mem[wr_ptr] <= {push_ferr, push_perr, push_data};
  end

  always_ff @(posedge clock_115200hz or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_q && !wr_en) overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule
